// File: rtl/clock_time_keeper.sv
// Time-of-day keeper: 1 Hz prescaler plus hh:mm:ss counters with sync load.
// Optional alarm comparator enabled by defining CLOCK_ALARM_EN.
module clock_time_keeper #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int PRE_W    = 27
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic        time_ow,
  input  logic [16:0] time_in,
`ifdef CLOCK_ALARM_EN
  input  logic [16:0] alarm_time,
  output logic        alarm_hit,
`endif
  output logic [16:0] time_out,
  output logic        sec_tick,
  output logic        day_tick
);

  logic [PRE_W-1:0] r_pre;
  logic [16:0]      r_time;
  logic             r_sec_tick;
  logic             r_day_tick;

  logic [4:0]  w_hr;
  logic [5:0]  w_min;
  logic [5:0]  w_sec;
  logic        w_wrap;
  logic        w_adv;
  logic        w_sec_wr;
  logic        w_min_wr;
  logic        w_hr_wr;
  logic [16:0] w_nxt;
  logic [16:0] w_ld;

  assign w_hr  = r_time[16:12];
  assign w_min = r_time[11:6];
  assign w_sec = r_time[5:0];

  assign w_wrap = (r_pre == PRE_W'(CLK_FREQ - 1));
  assign w_adv  = run & w_wrap & ~time_ow;

  assign w_sec_wr = (w_sec == 6'd59);
  assign w_min_wr = (w_min == 6'd59);
  assign w_hr_wr  = (w_hr == 5'd23);

  // Every carry is decoded from the current value, so the whole
  // rollover lands on one edge.
  assign w_nxt[5:0]   = w_sec_wr ? 6'd0 : w_sec + 6'd1;
  assign w_nxt[11:6]  = !w_sec_wr ? w_min :
                        (w_min_wr ? 6'd0 : w_min + 6'd1);
  assign w_nxt[16:12] = !(w_sec_wr && w_min_wr) ? w_hr :
                        (w_hr_wr ? 5'd0 : w_hr + 5'd1);

  assign w_ld[16:12] = (time_in[16:12] > 5'd23) ? 5'd0 : time_in[16:12];
  assign w_ld[11:6]  = (time_in[11:6] > 6'd59) ? 6'd0 : time_in[11:6];
  assign w_ld[5:0]   = (time_in[5:0] > 6'd59) ? 6'd0 : time_in[5:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre      <= '0;
      r_time     <= '0;
      r_sec_tick <= 1'b0;
      r_day_tick <= 1'b0;
    end else if (time_ow) begin
      r_pre      <= '0;
      r_time     <= w_ld;
      r_sec_tick <= 1'b0;
      r_day_tick <= 1'b0;
    end else if (w_adv) begin
      r_pre      <= '0;
      r_time     <= w_nxt;
      r_sec_tick <= 1'b1;
      r_day_tick <= w_sec_wr & w_min_wr & w_hr_wr;
    end else begin
      if (run) r_pre <= r_pre + PRE_W'(1);
      r_sec_tick <= 1'b0;
      r_day_tick <= 1'b0;
    end
  end

  assign time_out = r_time;
  assign sec_tick = r_sec_tick;
  assign day_tick = r_day_tick;

`ifdef CLOCK_ALARM_EN
  logic r_armed;
  logic r_alarm_hit;
  logic w_hit;

  assign w_hit = w_adv & r_armed & (w_nxt == alarm_time);

  // Armed drops on a hit so a held match fires once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_armed     <= 1'b1;
      r_alarm_hit <= 1'b0;
    end else begin
      r_alarm_hit <= w_hit;
      if (w_hit) r_armed <= 1'b0;
      else if (r_time != alarm_time) r_armed <= 1'b1;
    end
  end

  assign alarm_hit = r_alarm_hit;
`endif

endmodule

// File: tb/tb_clock_time_keeper.sv
// Directed bench for clock_time_keeper at CLK_FREQ=4.
// Alarm scenario is included when CLOCK_ALARM_EN is defined.
module tb_clock_time_keeper;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic        time_ow;
  logic [16:0] time_in;
  logic [16:0] time_out;
  logic        sec_tick;
  logic        day_tick;
`ifdef CLOCK_ALARM_EN
  logic [16:0] alarm_time;
  logic        alarm_hit;
`endif

  int n_chk = 0;
  int n_err = 0;

  clock_time_keeper #(.CLK_FREQ(4), .PRE_W(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run),
    .time_ow   (time_ow),
    .time_in   (time_in),
`ifdef CLOCK_ALARM_EN
    .alarm_time(alarm_time),
    .alarm_hit (alarm_hit),
`endif
    .time_out  (time_out),
    .sec_tick  (sec_tick),
    .day_tick  (day_tick)
  );

  always #5 clk = ~clk;

  function automatic logic [16:0] mk(int h, int m, int s);
    return {5'(h), 6'(m), 6'(s)};
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load(logic [16:0] v);
    time_ow = 1'b1;
    time_in = v;
    step(1);
    time_ow = 1'b0;
  endtask

  initial begin
    rst_n   = 1'b0;
    run     = 1'b0;
    time_ow = 1'b0;
    time_in = '0;
`ifdef CLOCK_ALARM_EN
    alarm_time = mk(20, 0, 0);
`endif
    #12;
    chk("rst_time", 32'(time_out), 0);
    chk("rst_stick", 32'(sec_tick), 0);
    chk("rst_dtick", 32'(day_tick), 0);
    rst_n = 1'b1;
    run   = 1'b1;

    for (int i = 1; i <= 8; i++) begin
      step(1);
      chk("t1_stick", 32'(sec_tick), 32'(i % 4 == 0));
      chk("t1_time", 32'(time_out), 32'(mk(0, 0, i / 4)));
      chk("t1_dtick", 32'(day_tick), 0);
    end

    load(mk(23, 59, 58));
    chk("t2_load", 32'(time_out), 32'(mk(23, 59, 58)));
    chk("t2_ld_stick", 32'(sec_tick), 0);
    step(4);
    chk("t2_59", 32'(time_out), 32'(mk(23, 59, 59)));
    chk("t2_59_stick", 32'(sec_tick), 1);
    chk("t2_59_dtick", 32'(day_tick), 0);
    step(4);
    chk("t2_roll", 32'(time_out), 0);
    chk("t2_roll_stick", 32'(sec_tick), 1);
    chk("t2_roll_dtick", 32'(day_tick), 1);
    step(1);
    chk("t2_dtick_off", 32'(day_tick), 0);
    chk("t2_stick_off", 32'(sec_tick), 0);

    load(mk(10, 59, 59));
    step(4);
    chk("t3_time", 32'(time_out), 32'(mk(11, 0, 0)));
    chk("t3_stick", 32'(sec_tick), 1);
    chk("t3_dtick", 32'(day_tick), 0);

    load(mk(25, 61, 30));
    chk("t4_time", 32'(time_out), 32'(mk(0, 0, 30)));
    chk("t4_dtick", 32'(day_tick), 0);
    load(mk(23, 0, 62));
    chk("t4_sec_bad", 32'(time_out), 32'(mk(23, 0, 0)));
    load(mk(12, 34, 56));
    chk("t4_valid", 32'(time_out), 32'(mk(12, 34, 56)));
    load(mk(0, 0, 0));
    chk("t4_zero", 32'(time_out), 0);
    chk("t4_zero_dtick", 32'(day_tick), 0);

    load(mk(0, 0, 30));
    step(3);
    chk("t5_pre3_stick", 32'(sec_tick), 0);
    chk("t5_pre3_time", 32'(time_out), 32'(mk(0, 0, 30)));
    time_ow = 1'b1;
    time_in = mk(5, 6, 7);
    step(1);
    time_ow = 1'b0;
    chk("t5_ld_time", 32'(time_out), 32'(mk(5, 6, 7)));
    chk("t5_ld_stick", 32'(sec_tick), 0);
    step(3);
    chk("t5_early_stick", 32'(sec_tick), 0);
    chk("t5_early_time", 32'(time_out), 32'(mk(5, 6, 7)));
    step(1);
    chk("t5_tick", 32'(sec_tick), 1);
    chk("t5_tick_time", 32'(time_out), 32'(mk(5, 6, 8)));

    step(2);
    run = 1'b0;
    step(5);
    chk("hold_time", 32'(time_out), 32'(mk(5, 6, 8)));
    chk("hold_stick", 32'(sec_tick), 0);
    run = 1'b1;
    step(1);
    chk("resume_pre", 32'(sec_tick), 0);
    step(1);
    chk("resume_tick", 32'(sec_tick), 1);
    chk("resume_time", 32'(time_out), 32'(mk(5, 6, 9)));

    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_time", 32'(time_out), 0);
    chk("arst_stick", 32'(sec_tick), 0);
    step(2);
    chk("arst_hold", 32'(time_out), 0);
    rst_n = 1'b1;
    step(4);
    chk("arst_rel", 32'(time_out), 32'(mk(0, 0, 1)));
    chk("arst_rel_tick", 32'(sec_tick), 1);

`ifdef CLOCK_ALARM_EN
    rst_n = 1'b0;
    alarm_time = mk(0, 0, 2);
    #2;
    rst_n = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      step(1);
      chk("al_hit", 32'(alarm_hit), 32'(i == 8));
    end
    step(1);
    rst_n = 1'b0;
    #1;
    chk("al_rst_time", 32'(time_out), 0);
    chk("al_rst_hit", 32'(alarm_hit), 0);
    chk("al_rst_stick", 32'(sec_tick), 0);
    rst_n = 1'b1;
    load(mk(0, 0, 2));
    chk("al_ld_hit", 32'(alarm_hit), 0);
    step(1);
    chk("al_ld_hit2", 32'(alarm_hit), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
